fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_ir_stage.sv | 30 +++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, width defaults and halt opcode for the fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int PC_W_DEFAULT    = 16;
    localparam int INSTR_W_DEFAULT = 9;
    localparam logic [INSTR_W_DEFAULT-1:0] HALT_INSTR = 9'b000000000;
endpackage

// File: rtl/fetch_ir_stage.sv
// rtl/fetch_ir_stage.sv - instruction register (valid/data/pc) with load, hold and flush
module fetch_ir_stage #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [PC_W-1:0]    load_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic [PC_W-1:0]    ir_pc
);
    // Flush outranks load so a redirect can never let a stale fetch through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_valid <= 1'b0;
            ir_data  <= '0;
            ir_pc    <= '0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (load) begin
            ir_valid <= 1'b1;
            ir_data  <= load_data;
            ir_pc    <= load_pc;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - sequential fetch FSM with stall, redirect and drain; FETCH_HALT_EN enables halt-opcode stop
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int INSTR_W  = INSTR_W_DEFAULT,
    parameter int RESET_PC = 0,
    parameter int PROG_LEN = 55
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               busy,
    output logic               done
);
    localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);
    localparam logic [PC_W:0]   PROG_END = (PC_W+1)'(PROG_LEN);

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic            load, flush, in_prog, halt;

    assign in_prog = {1'b0, pc} < PROG_END;

`ifdef FETCH_HALT_EN
    assign halt = (instr_in == INSTR_W'(HALT_INSTR));
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= START_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        flush   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = START_PC;
                    flush   = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_n  = redirect_pc;
                    flush = 1'b1;
                end else if (in_prog) begin
                    if (!ir_valid || ir_ready) begin
                        if (halt) begin
                            // Halt word is never loaded; a held instruction accepted this cycle is retired.
                            flush   = ir_valid;
                            state_n = DRAIN;
                        end else begin
                            load = 1'b1;
                            pc_n = pc + PC_W'(1);
                        end
                    end
                end else begin
                    flush   = ir_valid && ir_ready;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    flush   = 1'b1;
                    state_n = RUN;
                end else if (!ir_valid || ir_ready) begin
                    flush   = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    fetch_ir_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_ir (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .flush     (flush),
        .load_data (instr_in),
        .load_pc   (pc),
        .ir_valid  (ir_valid),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc)
    );

    assign pc_out = pc;
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl (RESET_PC=8, PROG_LEN=12, ROM with halt word at 5)
module tb_fetch_ctrl;
    localparam int PC_W = 16;
    localparam int IW   = 9;

    logic            clk = 1'b0;
    logic            reset, start, ir_ready, redirect_valid;
    logic [PC_W-1:0] redirect_pc, pc_out, ir_pc;
    logic [IW-1:0]   instr_in, ir_data;
    logic            ir_valid, busy, done;

    int passed = 0;
    int total  = 0;
    logic [PC_W-1:0] exp_pc_q[$];

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom(input logic [PC_W-1:0] a);
        return (a == 16'd5) ? 9'd0 : (a[IW-1:0] ^ 9'h1A5);
    endfunction

    assign instr_in = rom(pc_out);

    fetch_ctrl #(.PC_W(PC_W), .INSTR_W(IW), .RESET_PC(8), .PROG_LEN(12)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_out(pc_out), .instr_in(instr_in),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done !== 1'b1; i++) step();
        check("done_reached", 32'(done), 32'd1);
    endtask

    // Monitor: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                check("unexpected_accept_pc", 32'(ir_pc), 32'hFFFF_FFFF);
            end else begin
                logic [PC_W-1:0] e;
                e = exp_pc_q.pop_front();
                check("sb_ir_pc", 32'(ir_pc), 32'(e));
                check("sb_ir_data", 32'(ir_data), 32'(rom(e)));
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd8);
        check("rst_ir_data", 32'(ir_data), 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;

        // Full program 8..11, done two cycles after last fetch
        ir_ready = 1'b1; start = 1'b1;
        for (int a = 8; a < 12; a++) exp_pc_q.push_back(PC_W'(a));
        step();
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        check("run_first_pc", 32'(pc_out), 32'd8);
        check("run_ir_valid0", 32'(ir_valid), 32'd0);
        step();
        check("first_ir_pc", 32'(ir_pc), 32'd8);
        for (int i = 0; i < 4; i++) step();
        check("not_done_yet", 32'(done), 32'd0);
        step();
        check("done_two_after", 32'(done), 32'd1);
        check("done_pc_out", 32'(pc_out), 32'd12);

        // start with simultaneous redirect: redirect ignored
        ir_ready = 1'b0; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd3;
        step();
        check("start_wins_pc", 32'(pc_out), 32'd8);
        check("start_wins_valid", 32'(ir_valid), 32'd0);
        start = 1'b0; redirect_pc = 16'd2;
        step();
        redirect_valid = 1'b0;
        check("redir2_pc", 32'(pc_out), 32'd2);
        step();
        // Stall 3 cycles holding ir_pc=2
        for (int i = 0; i < 3; i++) begin
            check("stall_ir_pc", 32'(ir_pc), 32'd2);
            check("stall_ir_data", 32'(ir_data), 32'(rom(16'd2)));
            check("stall_pc_out", 32'(pc_out), 32'd3);
            check("stall_valid", 32'(ir_valid), 32'd1);
            step();
        end
        exp_pc_q.push_back(16'd2);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("release_ir_pc", 32'(ir_pc), 32'd3);

        // Redirect discards held instruction 3
        redirect_valid = 1'b1; redirect_pc = 16'd10;
        step();
        redirect_valid = 1'b0;
        check("redir_flush_valid", 32'(ir_valid), 32'd0);
        check("redir_pc_out", 32'(pc_out), 32'd10);
        ir_ready = 1'b1;
        exp_pc_q.push_back(16'd10);
        exp_pc_q.push_back(16'd11);
        step();
        check("redir_ir_pc", 32'(ir_pc), 32'd10);
        wait_done();

        // Redirect past the program: nothing fetched
        start = 1'b1;
        step();
        start = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'd13;
        step();
        redirect_valid = 1'b0;
        check("oob_valid", 32'(ir_valid), 32'd0);
        check("oob_pc_out", 32'(pc_out), 32'd13);
        wait_done();
        check("oob_pc_hold", 32'(pc_out), 32'd13);

        // Halt word at address 5
        start = 1'b1;
        step();
        start = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'd3;
`ifdef FETCH_HALT_EN
        exp_pc_q.push_back(16'd3);
        exp_pc_q.push_back(16'd4);
`else
        for (int a = 3; a < 12; a++) exp_pc_q.push_back(PC_W'(a));
`endif
        step();
        redirect_valid = 1'b0;
        wait_done();
`ifdef FETCH_HALT_EN
        check("halt_pc_out", 32'(pc_out), 32'd5);
`else
        check("nohalt_pc_out", 32'(pc_out), 32'd12);
`endif
        check("halt_queue_empty", 32'(exp_pc_q.size()), 32'd0);

        // Asynchronous reset between edges mid-RUN
        ir_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_rst_valid", 32'(ir_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(ir_valid), 32'd0);
        check("async_rst_pc", 32'(pc_out), 32'd8);
        check("async_rst_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_after_rst", {30'd0, ir_valid, busy}, 32'd0);
        end

        check("final_queue_empty", 32'(exp_pc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
